// File: rtl/display_scan_driver.sv
`timescale 1ns/1ps
// Multiplexed seven-segment scan driver: latches packed hex digits, decodes to active-low
// segments and scans DIGITS common-anode digits. Optional macro GHOST_BLANK_EN adds a dark lead-in per slot.
module display_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  blank_lz,
  output logic [6:0]            seg_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  // Elaboration-time guard on the legal parameter ranges.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("display_scan_driver: DIGITS must be 1..8");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("display_scan_driver: SCAN_DIV must be >= 2");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES > SCAN_DIV - 1) begin : g_bad_blank
    $error("display_scan_driver: BLANK_CYCLES must be 1..SCAN_DIV-1");
  end

  function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_shadow;
  logic [4*DIGITS-1:0]   r_pending;
  logic                  r_pending_valid;
  logic [6:0]            r_seg_n;
  logic [DIGITS-1:0]     r_an_n;
  logic                  r_frame_done;

  logic                  w_tc;
  logic                  w_idx_last;
  logic                  w_wrap;
  logic [DIGITS-1:0]     w_lz_blank;
  logic                  w_zero_run;
  logic [3:0]            w_nibble;
  logic                  w_slot_en;
  logic                  w_slot_lz;
  logic [DIGITS-1:0]     w_sel;
  logic                  w_ghost;
  logic                  w_blank;
  logic [6:0]            w_seg_next;
  logic [DIGITS-1:0]     w_an_next;

  assign w_tc       = (r_cnt == CNT_LAST);
  assign w_idx_last = (r_idx == IDX_LAST);
  assign w_wrap     = enable && w_tc && w_idx_last;

  // A digit above 0 is a leading zero when it and every digit above it are zero.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_lz_blank = '0;
    w_zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_run    = w_zero_run && (r_shadow[4*i +: 4] == 4'h0);
      w_lz_blank[i] = w_zero_run;
    end
  end

  always_comb begin
    w_nibble  = 4'h0;
    w_slot_en = 1'b0;
    w_slot_lz = 1'b0;
    w_sel     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nibble  = r_shadow[4*i +: 4];
        w_slot_en = digit_en[i];
        w_slot_lz = w_lz_blank[i];
        w_sel[i]  = 1'b1;
      end
    end
  end

`ifdef GHOST_BLANK_EN
  // Dark lead-in at the start of every slot lets the previous anode turn off cleanly.
  assign w_ghost = (r_cnt < CW'(BLANK_CYCLES));
`else
  assign w_ghost = 1'b0;
`endif

  assign w_blank = !w_slot_en || (blank_lz && w_slot_lz) || w_ghost;

  always_comb begin
    w_seg_next = 7'h7F;
    w_an_next  = '1;
    if (enable && !w_blank) begin
      w_seg_next = hex_to_seg_n(w_nibble);
      w_an_next  = ~w_sel;
    end
  end

  // Scan position: disabled holds at slot 0 / count 0 so re-enable starts a clean frame.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (!enable) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Display data: loads park in pending and reach shadow only at frame boundaries,
  // except a load on the wrap cycle which goes straight through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow        <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
    end else if (!enable) begin
      if (r_pending_valid) begin
        r_shadow <= r_pending;
      end
      if (load) begin
        r_pending       <= digits_in;
        r_pending_valid <= 1'b1;
      end else begin
        r_pending_valid <= 1'b0;
      end
    end else if (w_wrap) begin
      if (load) begin
        r_shadow        <= digits_in;
        r_pending_valid <= 1'b0;
      end else if (r_pending_valid) begin
        r_shadow        <= r_pending;
        r_pending_valid <= 1'b0;
      end
    end else if (load) begin
      r_pending       <= digits_in;
      r_pending_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_n      <= 7'h7F;
      r_an_n       <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_seg_n      <= w_seg_next;
      r_an_n       <= w_an_next;
      r_frame_done <= w_wrap;
    end
  end

  assign seg_n      = r_seg_n;
  assign an_n       = r_an_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_driver.sv
`timescale 1ns/1ps
// Scoreboard bench for display_scan_driver: stimulus queues the expected registered outputs
// per clock, a negedge monitor pops and compares them.
module tb_display_scan_driver;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYCLES = 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enable;
  logic                load;
  logic [4*DIGITS-1:0] digits_in;
  logic [DIGITS-1:0]   digit_en;
  logic                blank_lz;
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   an_n;
  logic                frame_done;

  typedef struct {
    int          tag;
    logic [11:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  display_scan_driver #(
    .DIGITS      (DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (load),
    .digits_in (digits_in),
    .digit_en  (digit_en),
    .blank_lz  (blank_lz),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Queue the outputs expected after the next rising edge, then advance one clock.
  task automatic expect_cycle(input logic [6:0] seg, input logic [3:0] an, input logic fd);
    exp_t e;
    e.tag = cyc + 1;
    e.val = {seg, an, fd};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One digit slot; optionally pulses load for one cycle at count ld_k.
  task automatic slot(input logic [6:0] seg, input logic [3:0] an, input logic fd_last,
                      input logic ld = 1'b0, input logic [15:0] ld_data = 16'h0,
                      input int ld_k = 0, input int n = SCAN_DIV);
    logic [6:0] s;
    logic [3:0] a;
    for (int k = 0; k < n; k++) begin
      s = seg;
      a = an;
`ifdef GHOST_BLANK_EN
      if (k < BLANK_CYCLES) begin
        s = 7'h7F;
        a = 4'hF;
      end
`endif
      if (ld && k == ld_k) begin
        load      = 1'b1;
        digits_in = ld_data;
      end
      expect_cycle(s, a, fd_last && (k == SCAN_DIV - 1));
      load = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].tag <= cyc) begin
      e = q.pop_front();
      if (e.tag < cyc) check($sformatf("late@%0d", e.tag), 16'(cyc), 16'(e.tag));
      else check($sformatf("out@%0d", e.tag), {4'h0, seg_n, an_n, frame_done}, {4'h0, e.val});
    end
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    load      = 1'b0;
    digits_in = '0;
    digit_en  = 4'hF;
    blank_lz  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_seg", 16'(seg_n), 16'h7F);
    check("reset_an", 16'(an_n), 16'hF);
    check("reset_fd", 16'(frame_done), 16'h0);

    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) expect_cycle(7'h7F, 4'hF, 1'b0);

    // Load while disabled: parked in pending, then applied on the next disabled cycle.
    load      = 1'b1;
    digits_in = 16'h1234;
    expect_cycle(7'h7F, 4'hF, 1'b0);
    load = 1'b0;
    expect_cycle(7'h7F, 4'hF, 1'b0);
    enable = 1'b1;

    repeat (2) begin
      slot(7'h19, 4'hE, 1'b0);
      slot(7'h30, 4'hD, 1'b0);
      slot(7'h24, 4'hB, 1'b0);
      slot(7'h79, 4'h7, 1'b1);
    end

    // Mid-frame load must not tear the frame in progress.
    slot(7'h19, 4'hE, 1'b0);
    slot(7'h30, 4'hD, 1'b0, 1'b1, 16'h8888, 1);
    slot(7'h24, 4'hB, 1'b0);
    slot(7'h79, 4'h7, 1'b1);

    // Load on the wrap cycle goes straight into the next frame.
    slot(7'h00, 4'hE, 1'b0);
    slot(7'h00, 4'hD, 1'b0);
    slot(7'h00, 4'hB, 1'b0);
    slot(7'h00, 4'h7, 1'b1, 1'b1, 16'hABCD, 3);

    slot(7'h21, 4'hE, 1'b0);
    slot(7'h46, 4'hD, 1'b0);
    slot(7'h03, 4'hB, 1'b0);
    slot(7'h08, 4'h7, 1'b1);

    blank_lz = 1'b1;
    slot(7'h21, 4'hE, 1'b0, 1'b1, 16'h0050, 0);
    slot(7'h46, 4'hD, 1'b0);
    slot(7'h03, 4'hB, 1'b0);
    slot(7'h08, 4'h7, 1'b1);

    slot(7'h40, 4'hE, 1'b0, 1'b1, 16'h0000, 0);
    slot(7'h12, 4'hD, 1'b0);
    slot(7'h7F, 4'hF, 1'b0);
    slot(7'h7F, 4'hF, 1'b1);

    slot(7'h40, 4'hE, 1'b0);
    slot(7'h7F, 4'hF, 1'b0, 1'b1, 16'h4321, 0);
    slot(7'h7F, 4'hF, 1'b0);
    slot(7'h7F, 4'hF, 1'b1);

    blank_lz = 1'b0;
    digit_en = 4'b1010;
    slot(7'h7F, 4'hF, 1'b0);
    slot(7'h24, 4'hD, 1'b0);
    slot(7'h7F, 4'hF, 1'b0);
    slot(7'h19, 4'h7, 1'b1);

    digit_en = 4'hF;
    slot(7'h79, 4'hE, 1'b0);
    slot(7'h24, 4'hD, 1'b0, 1'b1, 16'h8888, 1);
    slot(7'h30, 4'hB, 1'b0);
    slot(7'h19, 4'h7, 1'b0, 1'b0, 16'h0, 0, 2);

    // Asynchronous reset mid slot 3 with a pending load outstanding.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_seg", 16'(seg_n), 16'h7F);
    check("async_an", 16'(an_n), 16'hF);
    check("async_fd", 16'(frame_done), 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Shadow back to zero; the discarded pending 8888 must never appear.
    repeat (2) begin
      slot(7'h40, 4'hE, 1'b0);
      slot(7'h40, 4'hD, 1'b0);
      slot(7'h40, 4'hB, 1'b0);
      slot(7'h40, 4'h7, 1'b1);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    check("drain", 16'(q.size()), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
